control_unit: RTL and testbench

Multi-cycle control unit for the 64-bit RISC-V datapath. It accepts one 32-bit instruction at a time over a valid/ready handshake and decodes it. It then sequences the datapath control lines (register-file addresses and write enable, immediate, operand/writeback mux selects, ALU operation, data-memory write enable) across DECODE/EXECUTE/MEM/WRITEBACK states, and advances a program counter on every retire. It sits directly upstream of `cpu` and drives every one of its control inputs.

---
 rtl/cpu_pkg.sv | 41 ++++
 rtl/control_unit_if.sv | 9 +
 rtl/control_unit_imm_gen.sv | 24 ++
 rtl/control_unit.sv | 157 +++++++++++++++
 tb/tb_control_unit.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcode/funct constants, ALU codes and FSM encoding for control_unit
package cpu_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_OP    = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;

  localparam logic [2:0] F3_DOUBLE = 3'b011;
  localparam logic [2:0] F3_ADD    = 3'b000;

  localparam logic [6:0] F7_ADD = 7'b0000000;
  localparam logic [6:0] F7_SUB = 7'b0100000;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_EXECUTE,
    S_MEM,
    S_WRITEBACK
  } state_e;

  typedef enum logic [2:0] {
    K_ILLEGAL,
    K_LD,
    K_SD,
    K_ADD,
    K_SUB,
    K_ADDI
  } kind_e;

  typedef enum logic [1:0] {
    IMM_I,
    IMM_S,
    IMM_R
  } imm_sel_e;

endpackage

// File: rtl/control_unit_if.sv
// rtl/control_unit_if.sv - instruction valid/ready handshake between fetch source and control_unit
interface control_unit_if;
  logic [31:0] cu_instr;
  logic        cu_instr_valid;
  logic        cu_instr_ready;

  modport master (output cu_instr, output cu_instr_valid, input cu_instr_ready);
  modport slave  (input cu_instr, input cu_instr_valid, output cu_instr_ready);
endinterface

// File: rtl/control_unit_imm_gen.sv
// rtl/control_unit_imm_gen.sv - I/S/R immediate extraction with sign extension to WORDSIZE
module imm_gen
  import cpu_pkg::*;
#(
  parameter int WORDSIZE = 64
) (
  input  logic [31:0]         instr,
  input  imm_sel_e            sel,
  output logic [WORDSIZE-1:0] imm
);

  always_comb begin
    imm = '0;
    case (sel)
      IMM_I:   imm = {{(WORDSIZE-12){instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{(WORDSIZE-12){instr[31]}}, instr[31:25], instr[11:7]};
      default: imm = '0;
    endcase
  end

  logic unused_bits;
  assign unused_bits = ^{instr[19:12], instr[6:0]};

endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - multi-cycle RV64 control unit; CONTROL_UNIT_ADDI_EN enables ADDI decode
module control_unit
  import cpu_pkg::*;
#(
  parameter int                  WORDSIZE = 64,
  parameter logic [WORDSIZE-1:0] RESET_PC = '0
) (
  input  logic                cu_clk,
  input  logic                cu_rst_n,
  control_unit_if.slave       instr_bus,
  output logic [4:0]          cu_rf_addr_a,
  output logic [4:0]          cu_rf_addr_b,
  output logic [4:0]          cu_rf_write_addr,
  output logic                cu_rf_write_en,
  output logic [WORDSIZE-1:0] cu_immediate,
  output logic                cu_mux_0_sel,
  output logic                cu_mux_1_sel,
  output logic                cu_mux_2_sel,
  output logic [2:0]          cu_alu_operation,
  output logic                cu_dm_write_en,
  output logic [WORDSIZE-1:0] cu_pc,
  output logic                cu_illegal
);

  state_e                state, state_d;
  kind_e                 kind;
  imm_sel_e              imm_sel;
  logic [31:0]           ir, ir_d;
  logic                  accept, ready_q, pc_step, writes_rf;
  logic [4:0]            addr_a_d, addr_b_d, waddr_d;
  logic                  mux0_d, mux1_d, mux2_d;
  logic [2:0]            alu_d;
  logic [WORDSIZE-1:0]   imm_d;

  assign instr_bus.cu_instr_ready = ready_q;
  assign accept = instr_bus.cu_instr_valid && ready_q && (state == S_IDLE);
  // Outside the accept edge ir_d equals ir, so the decoded kind is stable for the whole instruction.
  assign ir_d   = accept ? instr_bus.cu_instr : ir;

  always_comb begin
    kind = K_ILLEGAL;
    case (ir_d[6:0])
      OP_LOAD:  if (ir_d[14:12] == F3_DOUBLE) kind = K_LD;
      OP_STORE: if (ir_d[14:12] == F3_DOUBLE) kind = K_SD;
      OP_OP: begin
        if (ir_d[14:12] == F3_ADD) begin
          if (ir_d[31:25] == F7_ADD)      kind = K_ADD;
          else if (ir_d[31:25] == F7_SUB) kind = K_SUB;
        end
      end
`ifdef CONTROL_UNIT_ADDI_EN
      OP_IMM:   if (ir_d[14:12] == F3_ADD) kind = K_ADDI;
`endif
      default:  kind = K_ILLEGAL;
    endcase
  end

  always_comb begin
    addr_a_d  = '0;
    addr_b_d  = '0;
    waddr_d   = '0;
    mux0_d    = 1'b0;
    mux1_d    = 1'b0;
    mux2_d    = 1'b0;
    alu_d     = ALU_ADD;
    imm_sel   = IMM_R;
    writes_rf = 1'b0;
    case (kind)
      K_LD, K_ADDI: begin
        addr_a_d  = ir_d[19:15];
        addr_b_d  = ir_d[19:15];
        waddr_d   = ir_d[11:7];
        mux2_d    = (kind == K_LD);
        imm_sel   = IMM_I;
        writes_rf = 1'b1;
      end
      K_SD: begin
        addr_a_d = ir_d[24:20];
        addr_b_d = ir_d[19:15];
        mux0_d   = 1'b1;
        imm_sel  = IMM_S;
      end
      K_ADD, K_SUB: begin
        addr_a_d  = ir_d[19:15];
        addr_b_d  = ir_d[24:20];
        waddr_d   = ir_d[11:7];
        mux1_d    = 1'b1;
        alu_d     = (kind == K_SUB) ? ALU_SUB : ALU_ADD;
        writes_rf = 1'b1;
      end
      default: ;
    endcase
  end

  imm_gen #(.WORDSIZE(WORDSIZE)) u_imm_gen (
    .instr (ir_d),
    .sel   (imm_sel),
    .imm   (imm_d)
  );

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:      if (accept) state_d = S_DECODE;
      S_DECODE:    state_d = (kind == K_ILLEGAL) ? S_IDLE : S_EXECUTE;
      S_EXECUTE:   state_d = (kind == K_LD) ? S_MEM : S_WRITEBACK;
      S_MEM:       state_d = S_WRITEBACK;
      S_WRITEBACK: state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  assign pc_step = (state == S_WRITEBACK) || ((state == S_DECODE) && (kind == K_ILLEGAL));

  always_ff @(posedge cu_clk or negedge cu_rst_n) begin
    if (!cu_rst_n) state <= S_IDLE;
    else           state <= state_d;
  end

  // Outputs are registered against state_d so they line up with the state they belong to.
  always_ff @(posedge cu_clk or negedge cu_rst_n) begin
    if (!cu_rst_n) begin
      ready_q          <= 1'b1;
      ir               <= '0;
      cu_rf_addr_a     <= '0;
      cu_rf_addr_b     <= '0;
      cu_rf_write_addr <= '0;
      cu_rf_write_en   <= 1'b0;
      cu_immediate     <= '0;
      cu_mux_0_sel     <= 1'b0;
      cu_mux_1_sel     <= 1'b0;
      cu_mux_2_sel     <= 1'b0;
      cu_alu_operation <= ALU_ADD;
      cu_dm_write_en   <= 1'b0;
      cu_pc            <= RESET_PC;
      cu_illegal       <= 1'b0;
    end else begin
      ready_q        <= (state_d == S_IDLE);
      cu_rf_write_en <= (state_d == S_WRITEBACK) && writes_rf && (ir[11:7] != 5'd0);
      cu_dm_write_en <= (state_d == S_WRITEBACK) && (kind == K_SD);
      cu_illegal     <= accept && (kind == K_ILLEGAL);
      if (pc_step) cu_pc <= cu_pc + WORDSIZE'(4);
      if (accept) begin
        ir               <= ir_d;
        cu_rf_addr_a     <= addr_a_d;
        cu_rf_addr_b     <= addr_b_d;
        cu_rf_write_addr <= waddr_d;
        cu_immediate     <= imm_d;
        cu_mux_0_sel     <= mux0_d;
        cu_mux_1_sel     <= mux1_d;
        cu_mux_2_sel     <= mux2_d;
        cu_alu_operation <= alu_d;
      end
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - scoreboard bench for control_unit (honours CONTROL_UNIT_ADDI_EN)
module tb_control_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  control_unit_if bus ();
  control_unit_if bus2 ();

  logic [4:0]  rf_a, rf_b, rf_w, rf_a2, rf_b2, rf_w2;
  logic        rf_we, dm_we, m0, m1, m2, ill, rf_we2, dm_we2, m02, m12, m22, ill2;
  logic [2:0]  alu, alu2;
  logic [63:0] imm, pc, imm2, pc2;

  control_unit #(.WORDSIZE(64), .RESET_PC(64'h0)) dut (
    .cu_clk(clk), .cu_rst_n(rst_n), .instr_bus(bus.slave),
    .cu_rf_addr_a(rf_a), .cu_rf_addr_b(rf_b), .cu_rf_write_addr(rf_w),
    .cu_rf_write_en(rf_we), .cu_immediate(imm), .cu_mux_0_sel(m0),
    .cu_mux_1_sel(m1), .cu_mux_2_sel(m2), .cu_alu_operation(alu),
    .cu_dm_write_en(dm_we), .cu_pc(pc), .cu_illegal(ill)
  );

  control_unit #(.WORDSIZE(64), .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut2 (
    .cu_clk(clk), .cu_rst_n(rst_n), .instr_bus(bus2.slave),
    .cu_rf_addr_a(rf_a2), .cu_rf_addr_b(rf_b2), .cu_rf_write_addr(rf_w2),
    .cu_rf_write_en(rf_we2), .cu_immediate(imm2), .cu_mux_0_sel(m02),
    .cu_mux_1_sel(m12), .cu_mux_2_sel(m22), .cu_alu_operation(alu2),
    .cu_dm_write_en(dm_we2), .cu_pc(pc2), .cu_illegal(ill2)
  );

  typedef struct {
    string       name;
    logic [4:0]  a, b, w;
    logic [63:0] imm;
    logic        m0, m1, m2;
    logic [2:0]  alu;
    int          rf_cyc, dm_cyc, rdy_cyc;
    bit          ill;
    logic [63:0] pc;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  logic [63:0] exp_pc = 64'h0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    if (!$isunknown(exp)) begin
      total++;
      assert (obs === exp) else begin
        bad++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
    end
  endtask

  function automatic exp_t mk(input string n, input logic [4:0] a, input logic [4:0] b,
                              input logic [4:0] w, input logic [63:0] i, input logic x0,
                              input logic x1, input logic x2, input logic [2:0] op,
                              input int rfc, input int dmc, input int rdy);
    exp_t e;
    e.name = n; e.a = a; e.b = b; e.w = w; e.imm = i;
    e.m0 = x0; e.m1 = x1; e.m2 = x2; e.alu = op;
    e.rf_cyc = rfc; e.dm_cyc = dmc; e.rdy_cyc = rdy; e.ill = 1'b0; e.pc = 'x;
    return e;
  endfunction

  function automatic exp_t mk_ill(input string n);
    exp_t e;
    e = mk(n, 'x, 'x, 'x, 'x, 'x, 'x, 'x, 'x, 0, 0, 2);
    e.ill = 1'b1;
    return e;
  endfunction

  // Issue one word, then follow it cycle by cycle until ready returns; hold keeps valid high with a junk word.
  task automatic run(input logic [31:0] word, input exp_t e, input bit hold);
    exp_t cur;
    int   c;
    bit   done;
    exp_pc = exp_pc + 64'd4;
    e.pc = exp_pc;
    sb.push_back(e);
    bus.cu_instr = word;
    bus.cu_instr_valid = 1'b1;
    c = 0;
    while (bus.cu_instr_ready !== 1'b1 && c < 10) begin
      @(negedge clk);
      c++;
    end
    chk({e.name, "_ready_in"}, 64'(bus.cu_instr_ready), 64'd1);
    @(posedge clk);
    #1;
    if (hold) bus.cu_instr = 32'hFE533C23;
    else      bus.cu_instr_valid = 1'b0;
    cur = sb.pop_front();
    done = 1'b0;
    for (int k = 1; k <= 8 && !done; k++) begin
      @(negedge clk);
      chk($sformatf("%s_rfwe_c%0d", cur.name, k), 64'(rf_we), 64'(k == cur.rf_cyc));
      chk($sformatf("%s_dmwe_c%0d", cur.name, k), 64'(dm_we), 64'(k == cur.dm_cyc));
      chk($sformatf("%s_ill_c%0d", cur.name, k), 64'(ill), 64'(cur.ill && k == 1));
      if (bus.cu_instr_ready !== 1'b1) begin
        chk($sformatf("%s_addr_a_c%0d", cur.name, k), 64'(rf_a), 64'(cur.a));
        chk($sformatf("%s_addr_b_c%0d", cur.name, k), 64'(rf_b), 64'(cur.b));
        chk($sformatf("%s_waddr_c%0d", cur.name, k), 64'(rf_w), 64'(cur.w));
        chk($sformatf("%s_imm_c%0d", cur.name, k), imm, cur.imm);
        chk($sformatf("%s_mux0_c%0d", cur.name, k), 64'(m0), 64'(cur.m0));
        chk($sformatf("%s_mux1_c%0d", cur.name, k), 64'(m1), 64'(cur.m1));
        chk($sformatf("%s_mux2_c%0d", cur.name, k), 64'(m2), 64'(cur.m2));
        chk($sformatf("%s_alu_c%0d", cur.name, k), 64'(alu), 64'(cur.alu));
      end else begin
        done = 1'b1;
        bus.cu_instr_valid = 1'b0;
        chk({cur.name, "_ready_cycle"}, 64'(k), 64'(cur.rdy_cyc));
        chk({cur.name, "_pc"}, pc, cur.pc);
      end
    end
    chk({cur.name, "_retired"}, 64'(done), 64'd1);
  endtask

  initial begin
    bit done;
    bus.cu_instr = '0;
    bus.cu_instr_valid = 1'b0;
    bus2.cu_instr = '0;
    bus2.cu_instr_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_pc", pc, 64'h0);
    chk("rst_ready", 64'(bus.cu_instr_ready), 64'd1);
    chk("rst_rfwe", 64'(rf_we), 64'd0);
    chk("rst_dmwe", 64'(dm_we), 64'd0);
    chk("rst_ill", 64'(ill), 64'd0);
    chk("rst_imm", imm, 64'h0);
    chk("rst_pc2", pc2, 64'hFFFF_FFFF_FFFF_FFFC);

    run(32'h0053B103, mk("ld", 7, 7, 2, 64'd5, 0, 0, 1, 3'b000, 4, 0, 5), 1'b0);
    run(32'h00413BA3, mk("sd", 4, 2, 'x, 64'h17, 1, 0, 'x, 3'b000, 0, 3, 4), 1'b0);
    run(32'h000100B3, mk("add", 2, 0, 1, 64'h0, 0, 1, 0, 3'b000, 3, 0, 4), 1'b1);
    run(32'h402000B3, mk("sub", 0, 2, 1, 64'h0, 0, 1, 0, 3'b001, 3, 0, 4), 1'b0);
`ifdef CONTROL_UNIT_ADDI_EN
    run(32'hFFF00193, mk("addi", 0, 0, 3, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 3'b000, 3, 0, 4), 1'b0);
`else
    run(32'hFFF00193, mk_ill("addi_off"), 1'b0);
`endif
    run(32'h00000000, mk_ill("zero"), 1'b0);
    run(32'h00208033, mk("add_x0", 1, 2, 0, 64'h0, 0, 1, 0, 3'b000, 0, 0, 4), 1'b0);
    run(32'hFE533C23, mk("sd_neg", 5, 6, 'x, 64'hFFFF_FFFF_FFFF_FFF8, 1, 0, 'x, 3'b000, 0, 3, 4), 1'b0);
    run(32'h0053A103, mk_ill("lw"), 1'b0);

    // Asynchronous reset landing in the EXECUTE cycle of an ADD.
    bus.cu_instr = 32'h000100B3;
    bus.cu_instr_valid = 1'b1;
    @(posedge clk);
    #1 bus.cu_instr_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pc", pc, 64'h0);
    chk("arst_ready", 64'(bus.cu_instr_ready), 64'd1);
    chk("arst_addr_a", 64'(rf_a), 64'd0);
    chk("arst_waddr", 64'(rf_w), 64'd0);
    chk("arst_mux1", 64'(m1), 64'd0);
    chk("arst_rfwe", 64'(rf_we), 64'd0);
    @(posedge clk);
    #1 chk("arst_rfwe_wb", 64'(rf_we), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_pc = 64'h0;
    @(negedge clk);
    run(32'h000100B3, mk("add_after_rst", 2, 0, 1, 64'h0, 0, 1, 0, 3'b000, 3, 0, 4), 1'b0);

    // PC wrap on the instance reset to the last word address.
    chk("wrap_pc_start", pc2, 64'hFFFF_FFFF_FFFF_FFFC);
    bus2.cu_instr = 32'h000100B3;
    bus2.cu_instr_valid = 1'b1;
    @(posedge clk);
    #1 bus2.cu_instr_valid = 1'b0;
    done = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (!done && bus2.cu_instr_ready === 1'b1) begin
        done = 1'b1;
        chk("wrap_ready_cycle", 64'(k), 64'd4);
        chk("wrap_pc", pc2, 64'h0);
      end
    end
    chk("wrap_retired", 64'(done), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
